// File: rtl/sseg_mux4.sv
// Four-digit seven-segment scan controller: rotates through the digits of a
// double-buffered BCD value, driving active-low anodes, BCD code and decimal point.
module sseg_mux4 #(
  parameter int DIV      = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic [3:0]  an,
  output logic [3:0]  bcd,
  output logic        dp
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [19:0]   shadow;
  logic [19:0]   disp;
  logic [19:0]   disp_nxt;
  logic          tick;
  logic          apply;
  logic [3:0]    blank;
  logic [3:0]    dig_nxt;
  logic          dpreq_nxt;

  // Outputs are computed from the index and display value as they will be
  // after this edge, so the new value appears exactly on the 3->0 wrap.
  always_comb begin
    tick     = (cnt == LAST);
    apply    = tick && (idx == 2'd3) && pending;
    idx_nxt  = idx + 2'd1;
    disp_nxt = apply ? shadow : disp;

    blank[0] = 1'b0;
    blank[3] = BLANK_LZ && (disp_nxt[19:16] == 4'h0);
    blank[2] = blank[3] && (disp_nxt[15:12] == 4'h0);
    blank[1] = blank[2] && (disp_nxt[11:8] == 4'h0);

    dig_nxt   = 4'h0;
    dpreq_nxt = 1'b0;
    case (idx_nxt)
      2'd0: begin dig_nxt = disp_nxt[7:4];   dpreq_nxt = disp_nxt[0]; end
      2'd1: begin dig_nxt = disp_nxt[11:8];  dpreq_nxt = disp_nxt[1]; end
      2'd2: begin dig_nxt = disp_nxt[15:12]; dpreq_nxt = disp_nxt[2]; end
      default: begin dig_nxt = disp_nxt[19:16]; dpreq_nxt = disp_nxt[3]; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      an      <= 4'b1110;
      bcd     <= 4'h0;
      dp      <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;

      if (apply)
        disp <= shadow;

      // A coincident load is captured after the apply has taken the old shadow.
      if (load) begin
        shadow  <= {digits_in, dp_in};
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end

      if (tick) begin
        idx <= idx_nxt;
        if (blank[idx_nxt]) begin
          an  <= 4'b1111;
          bcd <= 4'h0;
          dp  <= 1'b1;
        end else begin
          an  <= ~(4'b0001 << idx_nxt);
          bcd <= dig_nxt;
          dp  <= ~dpreq_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_mux4.sv
// Bench for sseg_mux4: two instances (blanking on/off) share stimulus and are
// compared every cycle against a slot/frame arithmetic model of the display.
module tb_sseg_mux4;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;

  logic        pending_b, pending_n;
  logic [3:0]  an_b, an_n, bcd_b, bcd_n;
  logic        dp_b, dp_n;

  int errors = 0;
  int checks = 0;

  // Model: edges since reset release, captured value, displayed value.
  int          k = 0;
  logic [19:0] m_shadow = '0;
  logic [19:0] m_shown  = '0;
  logic        m_pend   = 1'b0;

  always #5 clk = ~clk;

  sseg_mux4 #(.DIV(DIV), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .pending(pending_b), .an(an_b), .bcd(bcd_b), .dp(dp_b)
  );

  sseg_mux4 #(.DIV(DIV), .BLANK_LZ(1'b0)) dut_n (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .pending(pending_n), .an(an_n), .bcd(bcd_n), .dp(dp_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // Expected outputs derived from which slot is active and the shown value.
  task automatic expectFor(input bit blz, output logic [3:0] e_an,
                           output logic [3:0] e_bcd, output logic e_dp);
    int          slot;
    logic [15:0] d;
    logic [15:0] upper;
    slot  = (k / DIV) % 4;
    d     = m_shown[19:4];
    upper = d >> (4 * slot);
    if (blz && slot != 0 && upper == 16'h0) begin
      e_an  = 4'b1111;
      e_bcd = 4'h0;
      e_dp  = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << slot);
      e_bcd = upper[3:0];
      e_dp  = ~m_shown[slot];
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ld,
                               input logic [15:0] dg, input logic [3:0] dpv);
    logic [3:0] e_an, e_bcd;
    logic       e_dp;
    rst = r; load = ld; digits_in = dg; dp_in = dpv;
    @(posedge clk);
    if (r) begin
      k = 0; m_shadow = '0; m_shown = '0; m_pend = 1'b0;
    end else begin
      k++;
      if (k % FRAME == 0 && m_pend) begin
        m_shown = m_shadow;
        m_pend  = 1'b0;
      end
      if (ld) begin
        m_shadow = {dg, dpv};
        m_pend   = 1'b1;
      end
    end
    #1;
    expectFor(1'b1, e_an, e_bcd, e_dp);
    checkOutput("an_blz", 32'(an_b), 32'(e_an));
    checkOutput("bcd_blz", 32'(bcd_b), 32'(e_bcd));
    checkOutput("dp_blz", 32'(dp_b), 32'(e_dp));
    checkOutput("pending_blz", 32'(pending_b), 32'(m_pend));
    expectFor(1'b0, e_an, e_bcd, e_dp);
    checkOutput("an_noblz", 32'(an_n), 32'(e_an));
    checkOutput("bcd_noblz", 32'(bcd_n), 32'(e_bcd));
    checkOutput("dp_noblz", 32'(dp_n), 32'(e_dp));
    checkOutput("pending_noblz", 32'(pending_n), 32'(m_pend));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  // Advance until the model phase within the frame equals 'phase'.
  task automatic idleUntil(input int phase);
    int budget;
    budget = 0;
    while ((k % FRAME) != phase && budget < 4 * FRAME) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
      budget++;
    end
    if ((k % FRAME) != phase) checkOutput("phase_timeout", 32'(k % FRAME), 32'(phase));
  endtask

  initial begin
    // Reset and idle
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    idleCycles(32);

    // Basic scan
    applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0100);
    idleCycles(2 * FRAME);

    // Leading-zero blanking (both instances)
    applyStimulus(1'b0, 1'b1, 16'h0050, 4'b0000);
    idleCycles(2 * FRAME);

    // Frame integrity and latest-wins
    idleUntil(DIV);
    applyStimulus(1'b0, 1'b1, 16'h1111, 4'b0001);
    idleUntil(2 * DIV);
    applyStimulus(1'b0, 1'b1, 16'h2222, 4'b0010);
    idleCycles(2 * FRAME);

    // Load coincident with apply
    idleUntil(1);
    applyStimulus(1'b0, 1'b1, 16'h8888, 4'b1000);
    idleUntil(FRAME - 1);
    applyStimulus(1'b0, 1'b1, 16'h9999, 4'b1001);
    idleCycles(2 * FRAME);

    // Reset mid-frame with a value pending
    applyStimulus(1'b0, 1'b1, 16'h4321, 4'b0000);
    idleUntil(1);
    applyStimulus(1'b0, 1'b1, 16'h7777, 4'b1111);
    idleUntil(2 * DIV);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    idleCycles(2 * FRAME);

    // Randomized traffic including non-BCD codes and occasional reset
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 7) == 0),
                    16'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
